// File: rtl/seq_display_engine.sv
// seq_display_engine: captures a packed digit sequence on start and presents
// the digits one at a time, each one preceded by a blank gap. Both windows are
// timed in timebase ticks. The run can optionally replay, and it can be aborted.
module seq_display_engine #(
    parameter int DIGIT_W    = 4,
    parameter int MAX_DIGITS = 8,
    parameter int LVL_W      = 4,
    parameter int ON_TICKS   = 2,
    parameter int OFF_TICKS  = 1,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LVL_W-1:0]              curLvl,
    input  logic [DIGIT_W*MAX_DIGITS-1:0] seq,
    input  logic [1:0]                    repeats,
    input  logic                          tick,
    input  logic                          abort,
    output logic [DIGIT_W-1:0]            seqDigit,
    output logic                          showSeq,
    output logic [LVL_W-1:0]              digitIdx,
    output logic                          enable_to_timer,
    output logic                          busy,
    output logic                          displayDone,
    output logic                          aborted
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAP  = 3'd1,
        SHOW = 3'd2,
        DONE = 3'd3,
        ABRT = 3'd4
    } state_t;

    state_t                          state_q, state_d;
    logic [DIGIT_W*MAX_DIGITS-1:0]   seq_q, seq_d;
    logic [LVL_W-1:0]                lvl_q, lvl_d;
    logic [1:0]                      reps_q, reps_d;
    logic [1:0]                      rep_q, rep_d;
    logic [LVL_W-1:0]                idx_q, idx_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;

    logic [DIGIT_W-1:0]              seqDigit_q, seqDigit_d;
    logic                            showSeq_q, showSeq_d;
    logic [LVL_W-1:0]                digitIdx_q, digitIdx_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            aborted_q, aborted_d;

    logic [LVL_W-1:0]                eff_lvl;

    // Effective level: curLvl clamped to the sequence depth.
    always_comb begin
        eff_lvl = curLvl;
        if (curLvl > LVL_W'(MAX_DIGITS)) begin
            eff_lvl = LVL_W'(MAX_DIGITS);
        end
    end

    // Next-state logic: capture on start, tick-timed windows, replay and abort.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        lvl_d   = lvl_q;
        reps_d  = reps_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    seq_d   = seq;
                    reps_d  = repeats;
                    lvl_d   = eff_lvl;
                    rep_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (eff_lvl == '0) ? DONE : GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = ABRT;
                end else if (tick) begin
                    if (cnt_q == CNT_W'(OFF_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SHOW: begin
                if (abort) begin
                    state_d = ABRT;
                end else if (tick) begin
                    if (cnt_q == CNT_W'(ON_TICKS - 1)) begin
                        cnt_d = '0;
                        if ((idx_q + LVL_W'(1)) < lvl_q) begin
                            idx_d   = idx_q + LVL_W'(1);
                            state_d = GAP;
                        end else if (rep_q < reps_q) begin
                            rep_d   = rep_q + 2'd1;
                            idx_d   = '0;
                            state_d = GAP;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                // DONE and ABRT each last one cycle and drop the run counters.
                rep_d   = '0;
                idx_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        seqDigit_d = '0;
        showSeq_d  = 1'b0;
        digitIdx_d = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        unique case (state_d)
            GAP: begin
                busy_d     = 1'b1;
                digitIdx_d = idx_d;
            end
            SHOW: begin
                busy_d     = 1'b1;
                showSeq_d  = 1'b1;
                digitIdx_d = idx_d;
                for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
                    if (idx_d == LVL_W'(k)) begin
                        seqDigit_d = seq_d[DIGIT_W*(MAX_DIGITS-k)-1 -: DIGIT_W];
                    end
                end
            end
            DONE:    done_d    = 1'b1;
            ABRT:    aborted_d = 1'b1;
            default: ;
        endcase
    end

    // State, capture and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            seq_q      <= '0;
            lvl_q      <= '0;
            reps_q     <= '0;
            rep_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            seqDigit_q <= '0;
            showSeq_q  <= 1'b0;
            digitIdx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            lvl_q      <= lvl_d;
            reps_q     <= reps_d;
            rep_q      <= rep_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            seqDigit_q <= seqDigit_d;
            showSeq_q  <= showSeq_d;
            digitIdx_q <= digitIdx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign seqDigit        = seqDigit_q;
    assign showSeq         = showSeq_q;
    assign digitIdx        = digitIdx_q;
    assign busy            = busy_q;
    assign enable_to_timer = busy_q;
    assign displayDone     = done_q;
    assign aborted         = aborted_q;

endmodule

// File: tb/tb_seq_display_engine.sv
// Bench for seq_display_engine: table of whole-run vectors, hand-written corner
// sequences and a randomized phase, all checked cycle by cycle against a
// window-queue reference model.
module tb_seq_display_engine;

    localparam int DW  = 4;
    localparam int MD  = 5;
    localparam int LW  = 4;
    localparam int ON  = 2;
    localparam int OFF = 1;
    localparam int CW  = 8;

    logic             clk = 1'b0;
    logic             rst, start, tick, abort;
    logic [LW-1:0]    curLvl;
    logic [DW*MD-1:0] seq;
    logic [1:0]       repeats;
    logic [DW-1:0]    seqDigit;
    logic             showSeq, enable_to_timer, busy, displayDone, aborted;
    logic [LW-1:0]    digitIdx;

    always #5 clk = ~clk;

    seq_display_engine #(
        .DIGIT_W(DW), .MAX_DIGITS(MD), .LVL_W(LW),
        .ON_TICKS(ON), .OFF_TICKS(OFF), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .curLvl(curLvl), .seq(seq),
        .repeats(repeats), .tick(tick), .abort(abort), .seqDigit(seqDigit),
        .showSeq(showSeq), .digitIdx(digitIdx), .enable_to_timer(enable_to_timer),
        .busy(busy), .displayDone(displayDone), .aborted(aborted)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a run is a queue of windows still to be shown.
    typedef struct {
        bit show;
        int idx;
        int dig;
        int left;
    } win_t;

    localparam int M_IDLE = 0, M_ACT = 1, M_DONE = 2, M_ABRT = 3;
    win_t wq[$];
    int   m_mode = M_IDLE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int L;
        win_t w;
        if (!rst) begin
            m_mode = M_IDLE;
            wq.delete();
            return;
        end
        case (m_mode)
            M_IDLE: if (start) begin
                L = (int'(curLvl) > MD) ? MD : int'(curLvl);
                wq.delete();
                for (int r = 0; r <= int'(repeats); r++) begin
                    for (int k = 0; k < L; k++) begin
                        w.show = 1'b0; w.idx = k; w.dig = 0; w.left = OFF;
                        wq.push_back(w);
                        w.show = 1'b1;
                        w.dig  = int'((seq >> (DW * (MD - 1 - k))) & 20'hF);
                        w.left = ON;
                        wq.push_back(w);
                    end
                end
                m_mode = (L == 0) ? M_DONE : M_ACT;
            end
            M_ACT: begin
                if (abort) begin
                    m_mode = M_ABRT;
                    wq.delete();
                end else if (tick) begin
                    wq[0].left = wq[0].left - 1;
                    if (wq[0].left == 0) begin
                        void'(wq.pop_front());
                        if (wq.size() == 0) m_mode = M_DONE;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        logic [31:0] e_dig, e_show, e_idx, e_busy;
        e_dig = 0; e_show = 0; e_idx = 0; e_busy = 0;
        if (m_mode == M_ACT) begin
            e_busy = 1;
            e_show = {31'd0, wq[0].show};
            e_idx  = wq[0].idx;
            e_dig  = wq[0].show ? wq[0].dig : 0;
        end
        check("seqDigit", 32'(seqDigit), e_dig);
        check("showSeq", 32'(showSeq), e_show);
        check("digitIdx", 32'(digitIdx), e_idx);
        check("busy", 32'(busy), e_busy);
        check("enable_to_timer", 32'(enable_to_timer), e_busy);
        check("displayDone", 32'(displayDone), (m_mode == M_DONE) ? 32'd1 : 32'd0);
        check("aborted", 32'(aborted), (m_mode == M_ABRT) ? 32'd1 : 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    typedef struct {
        logic [LW-1:0]    lvl;
        logic [DW*MD-1:0] sq;
        logic [1:0]       reps;
        int               period;
        int               n;
        logic [63:0]      exp;
        int               done_at;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int vi);
        vec_t v;
        int j, done_j;
        logic prev;
        logic [DW-1:0] shown[$];
        v = vecs[vi];
        curLvl = v.lvl; seq = v.sq; repeats = v.reps;
        start = 1'b1; tick = 1'b0; abort = 1'b0;
        cycle();
        start = 1'b0;
        j = 0; done_j = -1; prev = 1'b0;
        if (displayDone) done_j = 0;
        while (done_j < 0 && j < 3000) begin
            j++;
            tick = (j % v.period == 0);
            if (j == 5 && m_mode == M_ACT) begin
                start = 1'b1;
                seq   = DW*MD'($urandom);
            end else begin
                start = 1'b0;
            end
            cycle();
            if (showSeq && !prev) shown.push_back(seqDigit);
            prev = showSeq;
            if (displayDone) done_j = j;
        end
        tick = 1'b0; start = 1'b0;
        check($sformatf("vec%0d_done_at", vi), done_j, v.done_at);
        check($sformatf("vec%0d_n_shows", vi), shown.size(), v.n);
        for (int i = 0; i < v.n; i++) begin
            check($sformatf("vec%0d_digit%0d", vi, i),
                  (i < shown.size()) ? 32'(shown[i]) : 32'hFFFF,
                  32'((v.exp >> (60 - 4 * i)) & 64'hF));
        end
        cycle();
    endtask

    initial begin
        int saw_done;
        vecs[0] = '{4'd3, 20'h12345, 2'd0, 4, 3,  64'h1230_0000_0000_0000, 36};
        vecs[1] = '{4'd3, 20'h12345, 2'd2, 4, 9,  64'h1231_2312_3000_0000, 108};
        vecs[2] = '{4'd9, 20'h12345, 2'd0, 4, 5,  64'h1234_5000_0000_0000, 60};
        vecs[3] = '{4'd0, 20'h12345, 2'd0, 4, 0,  64'h0,                   0};
        vecs[4] = '{4'd5, 20'hA0F07, 2'd1, 3, 10, 64'hA0F0_7A0F_0700_0000, 90};
        vecs[5] = '{4'd2, 20'h98765, 2'd3, 2, 8,  64'h9898_9898_0000_0000, 48};

        rst = 1'b0; start = 1'b0; tick = 1'b0; abort = 1'b0;
        curLvl = '0; seq = '0; repeats = '0;
        cycle();
        cycle();
        check("reset_busy", 32'(busy), 0);
        check("reset_seqDigit", 32'(seqDigit), 0);
        rst = 1'b1;
        cycle();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Abort in the second show window, coincident with its first tick.
        curLvl = 4'd3; seq = 20'h12345; repeats = 2'd0; start = 1'b1;
        cycle();
        start = 1'b0; saw_done = 0;
        for (int j = 1; j <= 20; j++) begin
            tick  = (j % 4 == 0);
            abort = (j == 20);
            cycle();
            if (displayDone) saw_done++;
            if (j == 19) begin
                check("abort_pre_show", 32'(showSeq), 1);
                check("abort_pre_digit", 32'(seqDigit), 2);
            end
        end
        check("abort_pulse", 32'(aborted), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_show", 32'(showSeq), 0);
        abort = 1'b0; tick = 1'b0;
        cycle();
        check("abort_one_cycle", 32'(aborted), 0);
        check("abort_no_done", saw_done, 0);
        start = 1'b1;
        cycle();
        check("restart_after_abort", 32'(busy), 1);
        start = 1'b0; abort = 1'b1;
        cycle();
        abort = 1'b0;
        cycle();

        // Reset mid-show; a mid-run start pulse and seq change are ignored.
        curLvl = 4'd3; seq = 20'h12345; repeats = 2'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick  = (j % 4 == 0);
            start = (j == 5);
            if (j == 5) seq = 20'hFFFFF;
            cycle();
        end
        start = 1'b0; tick = 1'b0;
        check("midrun_show", 32'(showSeq), 1);
        check("midrun_digit", 32'(seqDigit), 1);
        rst = 1'b0;
        cycle();
        check("rst_show", 32'(showSeq), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_idx", 32'(digitIdx), 0);
        rst = 1'b1;
        cycle();
        check("rst_stays_idle", 32'(busy), 0);

        // Back-to-back runs with start held high and a tick every cycle.
        curLvl = 4'd1; seq = 20'h12345; repeats = 2'd0; start = 1'b1; tick = 1'b1;
        cycle();
        check("b2b_busy_j0", 32'(busy), 1);
        for (int j = 1; j <= 8; j++) begin
            cycle();
            if (j == 3 || j == 8) check($sformatf("b2b_done_j%0d", j), 32'(displayDone), 1);
            if (j == 4) check("b2b_idle_j4", 32'(busy), 0);
            if (j == 5) check("b2b_busy_j5", 32'(busy), 1);
        end
        start = 1'b0; tick = 1'b0;
        cycle();

        // Randomized phase.
        for (int i = 0; i < 800; i++) begin
            rst     = ($urandom % 100) != 0;
            start   = ($urandom % 4) == 0;
            curLvl  = LW'($urandom);
            seq     = DW*MD'($urandom);
            repeats = 2'($urandom);
            tick    = ($urandom % 3) == 0;
            abort   = ($urandom % 60) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_display_engine.md
# seq_display_engine

Parametrised sequence-display controller for the memory-game datapath. On `start` it captures a packed digit sequence and the number of digits to show. It then presents the digits one at a time on `seqDigit`/`showSeq`, alternating a blank gap and a show window. Durations are counted internally in `tick` pulses from the shared timebase. It sits between the level/sequence generator and the 7-segment driver, replaces the fixed five-digit controller, and adds configurable depth, on/off durations, abort and a replay-count mode.

## Interface
- `DIGIT_W`, 4: bits per digit.
- `MAX_DIGITS`, 8: sequence depth; `seq` holds `MAX_DIGITS` digits.
- `LVL_W`, 4: width of `curLvl`. Must satisfy `2^LVL_W > MAX_DIGITS`.
- `ON_TICKS`, 2: `tick` pulses per show window. Must be ≥1.
- `OFF_TICKS`, 1: `tick` pulses per gap window. Must be ≥1.
- `CNT_W`, 8: width of the internal tick counter. Must satisfy `2^CNT_W > max(ON_TICKS, OFF_TICKS)`.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `start` in 1: begin a display run. Sampled only in IDLE.
- `curLvl` in `LVL_W`: number of digits to show. Captured at start.
- `seq` in `DIGIT_W*MAX_DIGITS`: packed sequence. Digit 0 occupies the MS slice. Captured at start.
- `repeats` in 2: extra full replays after the first pass (0–3). Captured at start.
- `tick` in 1: single-cycle timebase pulse.
- `abort` in 1: cancel the current run.
- `seqDigit` out `DIGIT_W`: digit currently shown; 0 when blank.
- `showSeq` out 1: high during show windows.
- `digitIdx` out `LVL_W`: index of the digit being gapped or shown.
- `enable_to_timer` out 1: timebase enable; high whenever busy.
- `busy` out 1: high in GAP or SHOW.
- `displayDone` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse on abort.

## Operation
- All outputs are registered.
- Reset (`rst`=0 at an edge): state←IDLE; every output←0; all counters←0. Reset overrides any state mid-run.
- States:
  - IDLE, GAP, SHOW, DONE, ABRT.
- IDLE:
  - Outputs 0.
  - On `start`=1, capture `seq`, `repeats`, and the effective level `L = min(curLvl, MAX_DIGITS)`. Clear `digitIdx` and the tick counter.
  - If L=0, go to DONE. Otherwise go to GAP.
- GAP:
  - `showSeq`=0, `seqDigit`=0, `busy`=1, `enable_to_timer`=1.
  - Each `tick` increments the tick counter.
  - On the `tick` that brings the count to `OFF_TICKS`, clear the counter and go to SHOW.
- SHOW:
  - `showSeq`=1, `seqDigit` = captured digit[`digitIdx`].
  - On the `tick` reaching `ON_TICKS`, clear the counter, then:
    - if `digitIdx`<L−1: increment `digitIdx`, go to GAP;
    - else if the replay counter < captured `repeats`: increment the replay counter, clear `digitIdx`, go to GAP;
    - else go to DONE.
- DONE: one cycle. `displayDone`=1, other outputs 0. Then IDLE.
- ABRT: one cycle. `aborted`=1, other outputs 0. Then IDLE.
- `abort`=1 in GAP or SHOW goes to ABRT. It takes priority over a coincident `tick`. `abort` is ignored in IDLE/DONE/ABRT.
- `start` is ignored outside IDLE. Changes on `seq`/`curLvl` after capture have no effect.
- `tick` arriving in IDLE/DONE/ABRT is ignored. The tick counter is cleared on every GAP/SHOW entry.
- Digit slicing: digit k = `seq[DIGIT_W*(MAX_DIGITS-k)-1 -: DIGIT_W]`.

## Timing
- `start` sampled at edge E: at E+1, `busy`=`enable_to_timer`=1 and the block is in GAP.
- A window ends at the edge that samples its final qualifying `tick`. The new state's outputs are visible from the next cycle.
- Total run length is L·(OFF_TICKS+ON_TICKS)·(repeats+1) tick pulses, plus one DONE cycle.
- `displayDone` and `aborted` are exactly one cycle wide and never asserted together. The earliest `start` accepted after completion is the cycle after DONE (IDLE).
- L=0: `displayDone` is at E+1 and `busy` never rises.

## Test plan
- Parameters DIGIT_W=4, MAX_DIGITS=5, LVL_W=4, ON=2, OFF=1. Inputs `seq`=20'h12345, `curLvl`=3, `repeats`=0, `tick` every 4th cycle → `seqDigit` shows 1,2,3, each for 2 ticks with 1-tick blanks. `displayDone` pulses once; `busy` falls the same cycle.
- Same setup, `repeats`=2 → the sequence 1,2,3 appears three times, `digitIdx` wraps 2→0 between passes, and there is one `displayDone`.
- `curLvl`=9 with MAX_DIGITS=5 → L clamps to 5; digits 1..5 are shown. `curLvl`=0 → `displayDone` at E+1 with no show window.
- `abort` asserted in the second SHOW window, coincident with `tick` → ABRT. `aborted` pulses once, outputs are 0, `displayDone` is never asserted, and the next `start` is accepted.
- `rst`=0 mid-SHOW → next cycle all outputs are 0 and the block is in IDLE. `start` pulsed while busy and `seq` changed mid-run → no effect on the shown digits.
- Back-to-back runs: `start` held high continuously → a new run begins the cycle after each DONE.
